// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    MWAIT  = 2'd2,
    ERR    = 2'd3
  } hz_state_t;

  localparam logic [4:0] XZR             = 5'd31;
  localparam int         MEM_TIMEOUT_DEF = 15;
  localparam int         WAIT_W          = 4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use and data-memory-wait hazard control for the in-order pipeline.
// Handshake: mem_req with mem_ready low means the MEM stage is stalled; the access completes on mem_ready.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rb,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_to_reg,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_if,
  output logic             bubble_ex,
  output logic             freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [1:0]       hz_state
);

  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

  hz_state_t         state;
  hz_state_t         state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              mem_wait;

  // XZR reads as zero, so a load targeting it never produces a real dependency.
  assign load_use = ex_reg_write && ex_mem_to_reg && (ex_rd != XZR) &&
                    ((id_use_a && (id_rn == ex_rd)) || (id_use_b && (id_rb == ex_rd)));
  assign mem_wait = mem_req && !mem_ready;

  always_comb begin
    stall_if  = 1'b0;
    bubble_ex = 1'b0;
    freeze    = 1'b0;
    state_nxt = state;
    case (state)
      RUN: begin
        if (mem_wait) begin
          freeze    = 1'b1;
          state_nxt = MWAIT;
        end else if (load_use) begin
          stall_if  = 1'b1;
          bubble_ex = 1'b1;
          state_nxt = LSTALL;
        end
      end
      LSTALL: begin
        if (mem_wait) begin
          freeze    = 1'b1;
          state_nxt = MWAIT;
        end else begin
          state_nxt = RUN;
        end
      end
      MWAIT: begin
        freeze = mem_wait;
        if (!mem_wait)                       state_nxt = RUN;
        else if (wait_cnt == TIMEOUT_CNT)    state_nxt = ERR;
      end
      ERR: begin
        freeze   = 1'b1;
        stall_if = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
    if (!reset) begin
      stall_if  = 1'b0;
      bubble_ex = 1'b0;
      freeze    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state != MWAIT) && (state_nxt == MWAIT)) begin
        wait_cnt <= '0;
      end else if ((state == MWAIT) && mem_wait && (wait_cnt != TIMEOUT_CNT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state_nxt == ERR) mem_timeout <= 1'b1;
    end
  end

  assign hz_state = state;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_if | freeze),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed hazard scenarios plus random traffic against a cycle model.
module tb_pipeline_hazard_ctrl;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rn, id_rb, ex_rd;
  logic        id_use_a, id_use_b, ex_reg_write, ex_mem_to_reg, mem_req, mem_ready;
  logic        stall_if, bubble_ex, freeze, mem_timeout;
  logic [15:0] stall_cycles;
  logic [1:0]  hz_state;
  logic        s4_stall_if, s4_bubble_ex, s4_freeze, s4_mem_timeout;
  logic [3:0]  s4_stall_cycles;
  logic [1:0]  s4_hz_state;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rb(id_rb), .id_use_a(id_use_a),
    .id_use_b(id_use_b), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_if(stall_if), .bubble_ex(bubble_ex), .freeze(freeze),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .hz_state(hz_state)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rb(id_rb), .id_use_a(id_use_a),
    .id_use_b(id_use_b), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_if(s4_stall_if), .bubble_ex(s4_bubble_ex), .freeze(s4_freeze),
    .mem_timeout(s4_mem_timeout), .stall_cycles(s4_stall_cycles), .hz_state(s4_hz_state)
  );

  logic [25:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  int m_state, m_wcnt, m_sc16, m_sc4;
  bit m_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_wcnt  = 0;
    m_to    = 1'b0;
    m_sc16  = 0;
    m_sc4   = 0;
  endtask

  // One clock cycle: drive just after negedge, predict, compare, advance the model.
  task automatic cycle(input logic [4:0] rn, input logic [4:0] rb, input logic ua,
                       input logic ub, input logic [4:0] erd, input logic erw,
                       input logic emr, input logic mreq, input logic mrdy);
    logic        lu, mw, si, bx, fr;
    int          nxt;
    logic [25:0] e;
    id_rn = rn; id_rb = rb; id_use_a = ua; id_use_b = ub; ex_rd = erd;
    ex_reg_write = erw; ex_mem_to_reg = emr; mem_req = mreq; mem_ready = mrdy;
    if (!reset) model_reset();
    lu = erw && emr && (erd != 5'd31) && ((ua && rn == erd) || (ub && rb == erd));
    mw = mreq && !mrdy;
    si = 1'b0; bx = 1'b0; fr = 1'b0; nxt = m_state;
    case (m_state)
      0: if (mw) begin fr = 1'b1; nxt = 2; end
         else if (lu) begin si = 1'b1; bx = 1'b1; nxt = 1; end
      1: begin fr = mw; nxt = mw ? 2 : 0; end
      2: begin fr = mw; nxt = !mw ? 0 : (m_wcnt == TMO ? 3 : 2); end
      default: begin fr = 1'b1; si = 1'b1; nxt = 3; end
    endcase
    if (!reset) begin si = 1'b0; bx = 1'b0; fr = 1'b0; end
    exp_q.push_back({si, bx, fr, m_to, 2'(m_state), 16'(m_sc16), 4'(m_sc4)});
    #2;
    e = exp_q.pop_front();
    check("stall_if",     32'(stall_if),        32'(e[25]));
    check("bubble_ex",    32'(bubble_ex),       32'(e[24]));
    check("freeze",       32'(freeze),          32'(e[23]));
    check("mem_timeout",  32'(mem_timeout),     32'(e[22]));
    check("hz_state",     32'(hz_state),        32'(e[21:20]));
    check("stall_cycles", 32'(stall_cycles),    32'(e[19:4]));
    check("stall_cnt_w4", 32'(s4_stall_cycles), 32'(e[3:0]));
    if (reset) begin
      if (m_state != 2 && nxt == 2) m_wcnt = 0;
      else if (m_state == 2 && mw && m_wcnt < TMO) m_wcnt++;
      if (nxt == 3) m_to = 1'b1;
      if (si || fr) begin
        if (m_sc16 < 65535) m_sc16++;
        if (m_sc4 < 15) m_sc4++;
      end
      m_state = nxt;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Reset with a live load-use pattern on the inputs so gating is exercised.
  task automatic do_reset();
    reset = 1'b0;
    cycle(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
  endtask

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom_range(0, 5);
    return (r == 5) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();
    check("reset_state", 32'(hz_state), 32'd0);

    // Load into X3 with a dependent reader: one-cycle bubble.
    cycle(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    check("lu_state_lstall", 32'(hz_state), 32'd1);
    cycle(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    check("lu_state_run", 32'(hz_state), 32'd0);
    check("lu_stall_cycles", 32'(stall_cycles), 32'd1);
    idle();

    // Load into XZR never stalls.
    do_reset();
    cycle(5'd31, 5'd0, 1'b1, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b1);
    check("xzr_stall_if", 32'(stall_if), 32'd0);
    cycle(5'd31, 5'd31, 1'b1, 1'b1, 5'd31, 1'b1, 1'b1, 1'b0, 1'b1);
    check("xzr_stall_cycles", 32'(stall_cycles), 32'd0);

    // Three memory wait cycles, then ready.
    do_reset();
    repeat (3) cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("mw_state", 32'(hz_state), 32'd2);
    cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("mw_stall_cycles", 32'(stall_cycles), 32'd3);
    check("mw_back_to_run", 32'(hz_state), 32'd0);

    // Memory wait and load-use together: wait wins, bubble follows afterwards.
    do_reset();
    repeat (2) cycle(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    check("both_run_after_ready", 32'(hz_state), 32'd0);
    cycle(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    check("both_lstall", 32'(hz_state), 32'd1);
    check("both_stall_cycles", 32'(stall_cycles), 32'd3);

    // Memory hang: timeout into ERR, inputs ignored, then reset mid-ERR.
    do_reset();
    repeat (20) cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("err_state", 32'(hz_state), 32'd3);
    check("err_timeout", 32'(mem_timeout), 32'd1);
    check("err_stall_cycles", 32'(stall_cycles), 32'd20);
    check("sat_w4", 32'(s4_stall_cycles), 32'd15);
    repeat (3) cycle(pick_reg(), pick_reg(), 1'b1, 1'b1, pick_reg(), 1'b1, 1'b1, 1'b0, 1'b1);
    check("err_sticky", 32'(hz_state), 32'd3);
    reset = 1'b0;
    #1;
    check("rst_freeze", 32'(freeze), 32'd0);
    check("rst_stall_if", 32'(stall_if), 32'd0);
    check("rst_timeout", 32'(mem_timeout), 32'd0);
    check("rst_state", 32'(hz_state), 32'd0);
    #1;
    cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    idle();
    check("post_err_state", 32'(hz_state), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) reset = 1'b0;
      cycle(pick_reg(), pick_reg(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            pick_reg(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      reset = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
